pe_column_result_accumulator: RTL

- Sits directly downstream of top_pe_column and consumes its per-column pe_result bus.
- Per column: fuses the two 26-bit partial sums and applies the bit-weight shift (2*bw).
- Accumulates across all bit-weight passes and K/4 chunks of one output row.
- Presents the finished row of N results to the writeback stage over a valid/ready handshake.

---
 rtl/pe_column_pkg.sv | 27 ++
 rtl/pe_column_fuse_lane.sv | 78 +++++++
 rtl/pe_column_result_accumulator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pe_column_pkg.sv
// Shared definitions for the PE column result accumulator: default widths,
// the row FSM state type and the per-column fuse/shift helper.
package pe_column_pkg;

    localparam int ACC_WIDTH    = 26;
    localparam int RESULT_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Sign-extend and add the two partial sums, widen to the result width,
    // then apply the bit-weight shift of 2*bw (wrapping in RESULT_WIDTH bits).
    function automatic logic [RESULT_WIDTH-1:0] fuse_shift(
        input logic [ACC_WIDTH-1:0] lo,
        input logic [ACC_WIDTH-1:0] hi,
        input logic [1:0]           bw
    );
        logic [ACC_WIDTH:0]      fuse;
        logic [RESULT_WIDTH-1:0] ext;
        fuse = {lo[ACC_WIDTH-1], lo} + {hi[ACC_WIDTH-1], hi};
        ext  = {{(RESULT_WIDTH-ACC_WIDTH-1){fuse[ACC_WIDTH]}}, fuse};
        return ext << {bw, 1'b0};
    endfunction

endpackage

// File: rtl/pe_column_fuse_lane.sv
// One output column: fuses the lo/hi partial sums, applies the bit-weight
// shift and keeps the running accumulator for the row in progress.
// ACC_SAT_EN selects signed saturating accumulation instead of wrap-around.
module pe_column_fuse_lane
    import pe_column_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ACC_WIDTH-1:0]    lo,
    input  logic [ACC_WIDTH-1:0]    hi,
    input  logic [1:0]              bw,
    input  logic                    accept,
    input  logic                    replace,
    input  logic                    last,
`ifdef ACC_SAT_EN
    output logic                    clamp,
`endif
    output logic [RESULT_WIDTH-1:0] sum
);

    logic [RESULT_WIDTH-1:0] acc_q, acc_d;

`ifdef ACC_SAT_EN
    // Wide enough for a 27-bit fuse shifted by 6 plus a full accumulator.
    localparam int WIDE_W = RESULT_WIDTH + 8;

    logic [ACC_WIDTH:0] fuse;
    logic [WIDE_W-1:0]  term_w, base_w, sum_w;
    logic               sat_hi, sat_lo;

    // Exact sum in wide precision, then clamp to the signed result range.
    always_comb begin
        fuse   = {lo[ACC_WIDTH-1], lo} + {hi[ACC_WIDTH-1], hi};
        term_w = {{(WIDE_W-ACC_WIDTH-1){fuse[ACC_WIDTH]}}, fuse} << {bw, 1'b0};
        base_w = replace ? '0 : {{(WIDE_W-RESULT_WIDTH){acc_q[RESULT_WIDTH-1]}}, acc_q};
        sum_w  = base_w + term_w;
        sat_hi = !sum_w[WIDE_W-1] && (|sum_w[WIDE_W-2:RESULT_WIDTH-1]);
        sat_lo = sum_w[WIDE_W-1] && !(&sum_w[WIDE_W-2:RESULT_WIDTH-1]);
        clamp  = sat_hi | sat_lo;
        if (sat_hi) begin
            sum = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
        end else if (sat_lo) begin
            sum = {1'b1, {(RESULT_WIDTH-1){1'b0}}};
        end else begin
            sum = sum_w[RESULT_WIDTH-1:0];
        end
    end
`else
    logic [RESULT_WIDTH-1:0] term;

    // Wrap-around accumulate; a replacing beat starts the row from its term.
    always_comb begin
        term = fuse_shift(lo, hi, bw);
        sum  = replace ? term : acc_q + term;
    end
`endif

    // Next accumulator: hold, take this beat's sum, or clear after the last beat.
    always_comb begin
        // NOTE: default assignment first so every path drives acc_d (no latch).
        acc_d = acc_q;
        if (accept) begin
            acc_d = last ? '0 : sum;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        // NOTE: the accumulator is a real register that must start at zero, so
        // it is reset; sequential state is always written with <= .
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pe_column_result_accumulator.sv
// Accumulates per-column pe_result beats (all bit-weight passes and K/4
// chunks) into one output row and hands it to writeback over valid/ready.
// Optional macro ACC_SAT_EN: saturating arithmetic plus sticky sat_flag port.
module pe_column_result_accumulator
    import pe_column_pkg::*;
#(
    parameter int N     = 32,
    parameter int ROW_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [1:0]                in_bw,
    input  logic [ROW_W-1:0]          in_row,
    input  logic [2*ACC_WIDTH*N-1:0]  pe_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ROW_W-1:0]          out_row,
    output logic [RESULT_WIDTH*N-1:0] out_data,
    output logic [7:0]                beat_cnt,
`ifdef ACC_SAT_EN
    output logic                      sat_flag,
`endif
    output logic                      err_restart
);

    state_e                    state_q, state_d;
    logic                      out_valid_q, out_valid_d;
    logic [ROW_W-1:0]          out_row_q, out_row_d;
    logic [RESULT_WIDTH*N-1:0] out_data_q, out_data_d;
    logic [7:0]                beat_cnt_q, beat_cnt_d;
    logic                      err_q, err_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [RESULT_WIDTH*N-1:0] lane_sum;
    logic                      accept;
    logic                      replace;
`ifdef ACC_SAT_EN
    logic [N-1:0]              lane_clamp;
    logic                      sat_q, sat_d;
`endif

    // Slot is free when empty or being drained this cycle.
    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    // A beat starts a fresh row when flagged first or when no row is open.
    assign replace  = (state_q == IDLE) | in_first;

    for (genvar i = 0; i < N; i++) begin : g_lane
        pe_column_fuse_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .lo      (pe_result[2*ACC_WIDTH*i +: ACC_WIDTH]),
            .hi      (pe_result[2*ACC_WIDTH*i+ACC_WIDTH +: ACC_WIDTH]),
            .bw      (in_bw),
            .accept  (accept),
            .replace (replace),
            .last    (in_last),
`ifdef ACC_SAT_EN
            .clamp   (lane_clamp[i]),
`endif
            .sum     (lane_sum[RESULT_WIDTH*i +: RESULT_WIDTH])
        );
    end

    // Row FSM, beat counter, error flag and output slot next-state.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_data_d  = out_data_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        row_d       = row_q;
`ifdef ACC_SAT_EN
        sat_d       = sat_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (replace) begin
                row_d      = in_row;
                beat_cnt_d = 8'd1;
                state_d    = ACCUM;
                if ((state_q == ACCUM) && in_first) begin
                    err_d = 1'b1;
                end
            end else if (beat_cnt_q != 8'hFF) begin
                beat_cnt_d = beat_cnt_q + 8'd1;
            end
`ifdef ACC_SAT_EN
            if (|lane_clamp) begin
                sat_d = 1'b1;
            end
`endif
            if (in_last) begin
                out_valid_d = 1'b1;
                out_row_d   = replace ? in_row : row_q;
                out_data_d  = lane_sum;
                state_d     = IDLE;
                beat_cnt_d  = 8'd0;
            end
        end
    end

    // Control and output slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_data_q  <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            row_q       <= '0;
`ifdef ACC_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_data_q  <= out_data_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            row_q       <= row_d;
`ifdef ACC_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign out_valid   = out_valid_q;
    assign out_row     = out_row_q;
    assign out_data    = out_data_q;
    assign beat_cnt    = beat_cnt_q;
    assign err_restart = err_q;
`ifdef ACC_SAT_EN
    assign sat_flag    = sat_q;
`endif

endmodule
